// File: rtl/fifo784_reader_if.sv
// Output stream of the FIFO drain engine: valid/ready word with frame/row markers and indices.
interface fifo784_reader_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned RW = 5
);
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic [RW-1:0] m_row;
    logic [RW-1:0] m_col;

    modport master (
        output m_data, m_valid, m_sof, m_eol, m_eof, m_row, m_col,
        input  m_ready
    );

    modport slave (
        input  m_data, m_valid, m_sof, m_eol, m_eof, m_row, m_col,
        output m_ready
    );
endinterface

// File: rtl/fifo784_reader.sv
// Drains ROWS*COLS words per frame from the async FIFO read port into a small skid buffer and streams them out.
// Optional RD_STALL_STAT_EN adds stall_cnt/starve_cnt statistics ports.
module fifo784_reader #(
    parameter int unsigned W    = 32,
    parameter int unsigned ROWS = 28,
    parameter int unsigned COLS = 28,
    parameter int unsigned RL   = 1,
    parameter int unsigned RW   = 5
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     fifo_dout,
    input  logic             fifo_rempty,
    output logic             fifo_re,
    fifo784_reader_if.master m,
    output logic             busy,
    output logic             done
`ifdef RD_STALL_STAT_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      starve_cnt
`endif
);

    localparam int unsigned N   = ROWS * COLS;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int unsigned SD  = RL + 1;
    localparam int unsigned PW  = $clog2(SD);
    localparam int unsigned OW  = $clog2(SD + 1);
    localparam int unsigned IW  = $clog2(RL + 1);
    localparam int unsigned CRW = $clog2(2 * SD + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [RL-1:0] vpipe;
    logic [IW-1:0] inflight;
    logic [CW-1:0] iss_cnt;
    logic [CW-1:0] out_cnt;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [W-1:0]  mem [SD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic          out_valid;
    logic          pop;
    logic          push;
    logic          cancel;
    logic          start_go;
    logic          credit_ok;
    logic          last_beat;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reads still travelling through the FIFO RAM pipeline
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RL); i++) begin
            inflight = inflight + IW'(vpipe[i]);
        end
    end

    // Handshake, credit and read-issue decode
    always_comb begin
        out_valid = (occ != '0);
        pop       = out_valid && m.m_ready;
        cancel    = abort && ((state == S_RUN) || (state == S_FLUSH));
        start_go  = (state == S_IDLE) && start && !abort;
        credit_ok = (CRW'(inflight) + CRW'(occ) - CRW'(pop)) < CRW'(SD);
        fifo_re   = (state == S_RUN) && !abort && !fifo_rempty && credit_ok
                    && (iss_cnt < CW'(N));
        push      = vpipe[RL-1] && (state != S_ABORT) && !cancel;
        last_beat = pop && (out_cnt == CW'(N - 1));
    end

    always_ff @(posedge rclk) begin
        if (rrst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_go) state_nx = S_RUN;
            S_RUN: begin
                if (cancel)                                       state_nx = S_ABORT;
                else if (fifo_re && (iss_cnt == CW'(N - 1)))      state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (cancel)         state_nx = S_ABORT;
                else if (last_beat) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            S_ABORT: if (inflight == '0) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Markers are qualified by valid so they read 0 whenever the buffer is empty
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        m.m_valid = out_valid;
        m.m_data  = mem[rd_ptr];
        m.m_row   = row;
        m.m_col   = col;
        m.m_sof   = out_valid && (row == '0) && (col == '0);
        m.m_eol   = out_valid && (col == RW'(COLS - 1));
        m.m_eof   = out_valid && (row == RW'(ROWS - 1)) && (col == RW'(COLS - 1));
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= fifo_re;
            for (int i = 1; i < int'(RL); i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    // Issue/beat counters and row/column indices
    always_ff @(posedge rclk) begin
        if (rrst || start_go || cancel) begin
            iss_cnt <= '0;
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            if (fifo_re && (iss_cnt != CW'(N))) iss_cnt <= iss_cnt + CW'(1);
            if (pop && (out_cnt != CW'(N))) begin
                out_cnt <= out_cnt + CW'(1);
                if (col == RW'(COLS - 1)) begin
                    col <= '0;
                    row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst || cancel) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge rclk) begin
        if (push) mem[wr_ptr] <= fifo_dout;
    end

`ifdef RD_STALL_STAT_EN
    always_ff @(posedge rclk) begin
        if (rrst || start_go) begin
            stall_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            if (out_valid && !m.m_ready && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if ((state == S_RUN) && fifo_rempty && credit_ok && (starve_cnt != 16'hFFFF))
                starve_cnt <= starve_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo784_reader.sv
// Directed bench for fifo784_reader: default 28x28/RL=1 instance plus a 4x4/RL=2 instance.
module tb_fifo784_reader;

    localparam int N = 784;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rrst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] fifo_dout = '0;
    logic        fifo_rempty;
    logic        fifo_re;
    logic        busy;
    logic        done;

    logic        start2 = 1'b0;
    logic [31:0] dout2 = '0;
    logic [31:0] p1 = '0;
    logic        fifo_rempty2;
    logic        fifo_re2;
    logic        busy2;
    logic        done2;

    fifo784_reader_if #(.W(32), .RW(5)) s_if ();
    fifo784_reader_if #(.W(32), .RW(5)) s2_if ();

    fifo784_reader u_dut (
        .rclk(clk), .rrst(rrst), .start(start), .abort(abort),
        .fifo_dout(fifo_dout), .fifo_rempty(fifo_rempty), .fifo_re(fifo_re),
        .m(s_if.master), .busy(busy), .done(done)
    );

    fifo784_reader #(.W(32), .ROWS(4), .COLS(4), .RL(2), .RW(5)) u_dut2 (
        .rclk(clk), .rrst(rrst), .start(start2), .abort(1'b0),
        .fifo_dout(dout2), .fifo_rempty(fifo_rempty2), .fifo_re(fifo_re2),
        .m(s2_if.master), .busy(busy2), .done(done2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model, RL=1: word = base + read index, counts reads attempted while empty
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          underflow = 0;
    int unsigned base = 0;
    logic        fifo_clr = 1'b1;
    assign fifo_rempty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_cnt <= 0;
        end else if (fifo_re) begin
            if (wr_cnt == rd_cnt) underflow <= underflow + 1;
            fifo_dout <= base + 32'(rd_cnt);
            rd_cnt    <= rd_cnt + 1;
        end
    end

    // FIFO model, RL=2, prefilled with 16 words starting at 7000
    int wr2 = 16;
    int rd2 = 0;
    assign fifo_rempty2 = (wr2 == rd2);

    always @(posedge clk) begin
        if (fifo_re2) begin
            p1  <= 32'(7000 + rd2);
            rd2 <= rd2 + 1;
        end
        dout2 <= p1;
    end

    // Stream monitor for the main instance
    int          cyc = 0;
    int          idx = 0;
    int          iss = 0;
    int          acc = 0;
    int          first_re = -1;
    int          last_acc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          credit_bad = 0;
    int          empty_re_bad = 0;
    logic        hold_pend = 1'b0;
    logic [44:0] hold_snap = '0;
    logic [44:0] cur;
    logic [44:0] expv;
    logic        pop_tb;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            cur = {s_if.m_data, s_if.m_sof, s_if.m_eol, s_if.m_eof, s_if.m_row, s_if.m_col};
            pop_tb = s_if.m_valid && s_if.m_ready;
            if (rrst) begin
                idx = 0;
                hold_pend = 1'b0;
            end else if (start && !busy && !abort) begin
                idx = 0; iss = 0; acc = 0;
                first_re = -1; last_acc = -1;
                hold_pend = 1'b0;
            end else begin
                if (hold_pend)
                    check("hold", 64'({s_if.m_valid, cur}), 64'({1'b1, hold_snap}));
                if (fifo_re) begin
                    if (first_re < 0) first_re = cyc;
                    if (iss - acc - int'(pop_tb) >= 2) credit_bad++;
                    if (fifo_rempty) empty_re_bad++;
                    iss++;
                end
                if (pop_tb) begin
                    expv = {base + 32'(idx), idx == 0, (idx % 28) == 27, idx == N - 1,
                            5'(idx / 28), 5'(idx % 28)};
                    check("beat", 64'(cur), 64'(expv));
                    idx++;
                    acc++;
                    last_acc = cyc;
                end
                hold_pend = s_if.m_valid && !s_if.m_ready && !abort;
                hold_snap = cur;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Stream monitor for the RL=2 instance
    int cyc2 = 0;
    int idx2 = 0;
    int first2 = -1;
    int last2 = -1;
    int done2_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc2++;
            if (s2_if.m_valid && s2_if.m_ready && !rrst) begin
                check("beat2",
                      64'({s2_if.m_data, s2_if.m_sof, s2_if.m_eol, s2_if.m_eof, s2_if.m_row, s2_if.m_col}),
                      64'({32'(7000 + idx2), idx2 == 0, (idx2 % 4) == 3, idx2 == 15,
                           5'(idx2 / 4), 5'(idx2 % 4)}));
                if (idx2 == 0) first2 = cyc2;
                last2 = cyc2;
                idx2++;
            end
            if (done2) done2_cnt++;
        end
    end

    task automatic check_idle(input string tag);
        check(tag, 64'({fifo_re, s_if.m_valid, s_if.m_sof, s_if.m_eol, s_if.m_eof,
                        s_if.m_row, s_if.m_col, busy, done}), 64'(0));
    endtask

    task automatic load(input int unsigned b, input int n);
        fifo_clr = 1'b1;
        wr_cnt   = 0;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        base     = b;
        wr_cnt   = n;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for one done pulse; optional m_ready toggling and one FIFO word every 'feed' cycles
    task automatic wait_done(input string tag, input int budget, input bit tog, input int feed);
        int k;
        int d0;
        k  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            k++;
            if (tog) s_if.m_ready = ~s_if.m_ready;
            if (feed != 0 && (k % feed) == 0 && wr_cnt < N) wr_cnt++;
        end
        check(tag, 64'(done_cnt - d0), 64'(1));
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (idx < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 64'(idx >= target), 64'(1));
    endtask

    initial begin
        int k;
        int d0;
        int held;
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        int held;
        s_if.m_ready  = 1'b0;
        s2_if.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state");
        @(posedge clk); #1;
        rrst = 1'b0;

        // Prefilled frame, m_ready held high
        s_if.m_ready = 1'b1;
        load(0, N);
        pulse_start();
        wait_done("t1_done", 2000, 1'b0, 0);
        check("t1_beats", 64'(idx), 64'(N));
        check("t1_span", 64'(last_acc - first_re), 64'(785));
        check("t1_done_lat", 64'(done_cyc - last_acc), 64'(1));
        @(negedge clk);
        check("t1_busy_low", 64'(busy), 64'(0));

        // m_ready toggling every cycle
        @(posedge clk); #1;
        load(1000, N);
        pulse_start();
        wait_done("t2_done", 4000, 1'b1, 0);
        s_if.m_ready = 1'b1;
        check("t2_beats", 64'(idx), 64'(N));
        check("t2_credit", 64'(credit_bad), 64'(0));

        // FIFO trickle-fed one word every 5 cycles
        @(posedge clk); #1;
        load(2000, 0);
        pulse_start();
        wait_done("t3_done", 5000, 1'b0, 5);
        check("t3_beats", 64'(idx), 64'(N));
        check("t3_re_empty", 64'(empty_re_bad), 64'(0));
        check("t3_underflow", 64'(underflow), 64'(0));

        // Abort after 300 beats with two words outstanding
        @(posedge clk); #1;
        load(3000, N);
        d0 = done_cnt;
        pulse_start();
        wait_beats("t4_reach300", 300, 1000);
        check("t4_outstanding", 64'(iss - acc), 64'(2));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        k = 0;
        while (busy && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("t4_idle_lat", 64'(k), 64'(1));
        held = idx;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t4_no_valid", 64'(s_if.m_valid), 64'(0));
        check("t4_no_beats", 64'(idx), 64'(held));
        check("t4_no_done", 64'(done_cnt - d0), 64'(0));
        @(posedge clk); #1;
        load(4000, N);
        pulse_start();
        wait_done("t4_next_done", 2000, 1'b0, 0);
        check("t4_next_beats", 64'(idx), 64'(N));

        // Synchronous reset mid-frame, then a clean frame
        @(posedge clk); #1;
        load(5000, N);
        d0 = done_cnt;
        pulse_start();
        wait_beats("t5_reach100", 100, 1000);
        rrst = 1'b1;
        @(posedge clk); #1;
        rrst = 1'b0;
        @(negedge clk);
        check_idle("t5_reset_outs");
        check("t5_no_done", 64'(done_cnt - d0), 64'(0));
        @(posedge clk); #1;
        load(6000, N);
        pulse_start();
        wait_done("t5_next_done", 2000, 1'b0, 0);
        check("t5_next_beats", 64'(idx), 64'(N));

        // RL=2, 4x4 instance
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        k = 0;
        while (done2_cnt == 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_done", 64'(done2_cnt), 64'(1));
        check("t6_beats", 64'(idx2), 64'(16));
        check("t6_span", 64'(last2 - first2), 64'(15));
        @(negedge clk);
        check("t6_busy_low", 64'(busy2), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
